// File: rtl/sc_sched_pkg.sv
// Shared types and constants for the stochastic multiplier scheduler:
// FSM state encoding, LFSR geometry and default seeds.
package sc_sched_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  localparam logic [LFSR_W-1:0] DEF_SEED_A = 31'd1;
  localparam logic [LFSR_W-1:0] DEF_SEED_B = 31'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // x^31 + x^28 + 1 Fibonacci step: shift left, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
  endfunction

endpackage

// File: rtl/sc_mult_scheduler_if.sv
// Request/response bundle between the two requesters and the scheduler.
// master = host side, slave = scheduler side.
interface sc_mult_scheduler_if #(
  parameter int WIDTH    = 4,
  parameter int LEN_LOG2 = 4
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [WIDTH-1:0]  req_a0;
  logic [WIDTH-1:0]  req_b0;
  logic [WIDTH-1:0]  req_a1;
  logic [WIDTH-1:0]  req_b1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [LEN_LOG2:0] rsp_count;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_count
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_count
  );

endinterface

// File: rtl/sc_bipolar_mult.sv
// Bipolar stochastic multiplier: two reseedable LFSRs, operand comparators
// and a registered XNOR product bit.
module sc_bipolar_mult
  import sc_sched_pkg::*;
#(
  parameter int                WIDTH  = 4,
  parameter logic [LFSR_W-1:0] SEED_A = DEF_SEED_A,
  parameter logic [LFSR_W-1:0] SEED_B = DEF_SEED_B
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_bit
);

  logic [LFSR_W-1:0] r_lfsr_a;
  logic [LFSR_W-1:0] r_lfsr_b;
  logic              r_prod;
  logic [WIDTH-1:0]  w_rn_a;
  logic [WIDTH-1:0]  w_rn_b;
  logic              w_bit_a;
  logic              w_bit_b;

  assign w_rn_a  = r_lfsr_a[LFSR_W-1 -: WIDTH];
  assign w_rn_b  = r_lfsr_b[LFSR_W-1 -: WIDTH];
  assign w_bit_a = (w_rn_a < i_a);
  assign w_bit_b = (w_rn_b < i_b);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || i_load) begin
      r_lfsr_a <= SEED_A;
      r_lfsr_b <= SEED_B;
    end else if (i_en) begin
      r_lfsr_a <= lfsr_step(r_lfsr_a);
      r_lfsr_b <= lfsr_step(r_lfsr_b);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod <= 1'b0;
    end else if (i_en) begin
      r_prod <= ~(w_bit_a ^ w_bit_b);
    end
  end

  assign o_bit = r_prod;

endmodule

// File: rtl/sc_mult_scheduler.sv
// Round-robin scheduler sharing one stochastic multiplier between two
// requesters; runs a fixed reseeded window and returns the ones count.
module sc_mult_scheduler
  import sc_sched_pkg::*;
#(
  parameter int                WIDTH    = 4,
  parameter int                LEN_LOG2 = 4,
  parameter logic [LFSR_W-1:0] SEED_A   = DEF_SEED_A,
  parameter logic [LFSR_W-1:0] SEED_B   = DEF_SEED_B
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sc_mult_scheduler_if.slave   bus,
  output logic                 busy
);

  localparam int                WIN     = 2 ** LEN_LOG2;
  localparam logic [LEN_LOG2:0] WIN_CNT = (LEN_LOG2 + 1)'(WIN);

  state_e            r_state;
  logic              r_last_grant;
  logic              r_id;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [LEN_LOG2:0] r_bit_cnt;
  logic [LEN_LOG2:0] r_ones;

  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_sel;
  logic              w_run;
  logic              w_prod;

  // NOTE: w_grant gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_grant = 2'b00;
    if (rst_n && r_state == IDLE) begin
      case (bus.req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_accept = |(w_grant & bus.req_valid);
  assign w_sel    = w_grant[1];
  assign w_run    = (r_state == RUN);

  sc_bipolar_mult #(
    .WIDTH  (WIDTH),
    .SEED_A (SEED_A),
    .SEED_B (SEED_B)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_en   (w_run),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_bit  (w_prod)
  );

  // Bit counter 0 primes the product register; counts 1..WIN accumulate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_bit_cnt    <= '0;
      r_ones       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= RUN;
            r_id         <= w_sel;
            r_last_grant <= w_sel;
            r_a          <= w_sel ? bus.req_a1 : bus.req_a0;
            r_b          <= w_sel ? bus.req_b1 : bus.req_b0;
            r_bit_cnt    <= '0;
            r_ones       <= '0;
          end
        end
        RUN: begin
          r_bit_cnt <= r_bit_cnt + (LEN_LOG2 + 1)'(1);
          if (r_bit_cnt != '0) begin
            r_ones <= r_ones + (LEN_LOG2 + 1)'(w_prod);
          end
          if (r_bit_cnt == WIN_CNT) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = (r_state == DONE);
  assign bus.rsp_count = r_ones;
  assign bus.rsp_id    = r_id;
  assign busy          = (r_state != IDLE);

endmodule

// File: doc/sc_mult_scheduler.md
# sc_mult_scheduler

Shares one bipolar stochastic multiplier between two requesters. A round-robin arbiter accepts one operand pair at a time, reseeds and runs the stochastic datapath for a fixed bitstream window, counts the ones in the XNOR product stream and returns the count with a valid/ready handshake. It sits between the host-facing operand registers and the stochastic datapath, and replaces free-running windowing with deterministic, transaction-based sequencing.

## Interface
- WIDTH, 4, operand width; the random number is the top WIDTH bits of each LFSR
- LEN_LOG2, 4, window length is 2^LEN_LOG2 product bits
- SEED_A, 31'd1, LFSR A seed loaded on accept (must be nonzero)
- SEED_B, 31'd2, LFSR B seed loaded on accept (must be nonzero and differ from SEED_A)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  2  per-requester operand valid
- req_ready  out  2  per-requester accept; at most one bit high
- req_a0, req_b0  in  WIDTH  requester 0 operands
- req_a1, req_b1  in  WIDTH  requester 1 operands
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result consumed
- rsp_id  out  1  requester that owns the result
- rsp_count  out  LEN_LOG2+1  number of ones in the window, 0..2^LEN_LOG2
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: the arbiter picks one requester with req_valid=1 and asserts its req_ready (combinational, IDLE only).
  - Both valid: grant the requester other than last_grant.
  - One valid: grant it.
  - Handshake is req_valid & req_ready on a clock edge.
- Accept:
  - Latch both operands and the id.
  - Load LFSR A with SEED_A and LFSR B with SEED_B.
  - Clear the bit counter and ones counter.
  - Update last_grant.
  - Go to RUN.
- RUN: both LFSRs step every cycle (x^31+x^28+1: shift left, bit0 = q[30]^q[27]).
  - bitA = rnA < a, bitB = rnB < b (unsigned). rn is q[30:31-WIDTH].
  - Product bit = XNOR(bitA, bitB), registered inside the sub-module.
  - The first RUN cycle primes that register.
  - The ones counter adds the product bit on the next 2^LEN_LOG2 cycles.
  - RUN lasts 2^LEN_LOG2+1 cycles.
- DONE: rsp_valid=1, with rsp_count and rsp_id held stable. On rsp_valid & rsp_ready, go to IDLE.
- Width rule: the ones counter is LEN_LOG2+1 bits, so an all-ones window (2^LEN_LOG2) is representable. No overflow flag.
- req_ready=00 outside IDLE. Requesters stall and must hold their operands until accepted.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - rsp_valid=0, rsp_count=0, rsp_id=0, busy=0.
  - req_ready=00 while rst_n=0.
  - LFSRs hold their seeds.
- Reset mid-RUN or mid-DONE: the transaction is dropped, no response is produced, and the FSM is in IDLE on the cycle after the reset edge.
- rsp_ready held low: stay in DONE indefinitely with outputs stable.

## Timing
- Accept edge at cycle t: RUN spans cycles t+1 .. t+1+2^LEN_LOG2. rsp_valid rises at t+2+2^LEN_LOG2, which is 18 cycles with LEN_LOG2=4.
- Earliest response is consumed at the same edge it appears if rsp_ready=1. The next accept is then possible one cycle later, in IDLE.
- Minimum issue interval is 2^LEN_LOG2+3 cycles (19 at default).
- No combinational path from req_* to rsp_*.

## Structure
- Package sc_sched_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - the LFSR width (31) and tap indices (30, 27)
  - the default SEED_A/SEED_B
- Sub-module sc_bipolar_mult contains:
  - two 31-bit LFSRs with load/enable
  - the two WIDTH-bit comparators
  - the registered XNOR output bit
- The scheduler owns the FSM, arbiter, bit counter and ones counter.

## Test plan
- Requester 0: a=0, b=0 -> both bits always 0. rsp_count=16, rsp_id=0, rsp_valid 18 cycles after accept.
- Requester 1 only, a=0, b=15 with rsp_ready=1 -> rsp_id=1. rsp_count equals the golden LFSR model (16 minus the cycles where rnB<15). The result is identical on repeat because of reseeding.
- Both requesters held valid for 4 transactions -> grants 0,1,0,1. req_ready is never 11 and never asserted outside IDLE.
- rsp_ready low for 10 cycles in DONE -> rsp_valid, rsp_count and rsp_id stable. req_ready=00. Completes one cycle after rsp_ready rises.
- rst_n low for 1 cycle at RUN cycle 5 -> next cycle IDLE, busy=0, no rsp_valid. A fresh accept then returns the full model result.
- Random operands over 200 transactions vs the cycle-accurate golden model -> rsp_count matches exactly and is always ≤16. Issue interval ≥19 cycles.
